writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
//  Writeback stage downstream of the X (1-cycle ALU) and Y (4-stage multiplier) execute units.
//  Merges both result streams onto the single register-file write port.
//  X always wins a conflict. Displaced Y results wait in a small in-order buffer.
//  Older buffered Y writes are squashed by younger X writes to the same register (WAW).
//  Back-pressures the issue stage before the buffer can overflow.
// PARAMETERS
//  BUF_DEPTH     4   Y result buffer entries (power of 2, >=2)
//  STALL_MARGIN  2   assert wb_is_stall when free entries <= STALL_MARGIN
// PORTS
//  clock           in   1   rising-edge clock
//  reset           in   1   synchronous, active-high
//  x_wb_regdest    in   5   X result destination register
//  x_wb_writereg   in   1   X result valid
//  x_wb_wbvalue    in   32  X result value
//  y_wb_regdest    in   5   Y result destination register
//  y_wb_writereg   in   1   Y result valid
//  y_wb_wbvalue    in   32  Y result value (low word)
//  wb_rf_writereg  out  1   register-file write enable (registered)
//  wb_rf_regdest   out  5   register-file write address (registered)
//  wb_rf_wbvalue   out  32  register-file write data (registered)
//  wb_is_stall     out  1   stall request to the issue stage (registered)
//  wb_overflow     out  1   sticky error: a Y result was dropped because the buffer was full
// BEHAVIOUR
//  Reset: all outputs 0, buffer empty, rd/wr pointers 0; wb_overflow cleared only by reset.
//  Inputs with regdest==0 are treated as not valid; register 0 is never written.
//  Per-cycle selection, in priority order:
//   1. X valid: X is selected. The buffer head does not drain. A valid Y is enqueued.
//   2. X idle, buffer non-empty: the head is selected and popped. A valid Y is enqueued the same cycle.
//   3. X idle, buffer empty, Y valid: Y is selected directly and does not enter the buffer.
//   4. Nothing valid: wb_rf_writereg=0 next cycle; regdest and value hold their last values.
//  Latency: the selected result appears on the wb_rf_* outputs exactly 1 cycle later.
//  WAW squash (X selected with regdest r):
//   - Every valid buffer entry with regdest r is invalidated in that cycle.
//   - An incoming Y with regdest r the same cycle is discarded, not enqueued.
//   - Invalidated entries still occupy their slot. When popped they produce wb_rf_writereg=0.
//  Count is the number of occupied slots, including invalidated ones. It is updated as push - pop.
//   - A simultaneous push and pop leaves count unchanged.
//   - Pointers wrap modulo BUF_DEPTH.
//  wb_is_stall <= (BUF_DEPTH - next_count) <= STALL_MARGIN.
//   - Issue must accept it one cycle late; the margin covers Y results already in flight.
//  Full: a push with count==BUF_DEPTH and no pop that cycle drops the Y result.
//   - wb_overflow is set to 1 and stays set; buffer contents are unchanged.
//  A push into a full buffer that pops the same cycle (case 2) is legal.
//  Reset mid-operation discards all buffered entries; no write is issued for them.
// CONFIGURATION
//  WB_STATS_EN defined adds three output ports, all 32-bit, cleared by reset, wrapping at 2^32-1:
//   - wb_stat_xwrites: +1 per X write issued.
//   - wb_stat_ywrites: +1 per Y write issued.
//   - wb_stat_conflicts: +1 per cycle in which a Y result was enqueued.
//  Undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. X r3=0x11 only -> next cycle wb_rf_writereg=1, regdest=3, wbvalue=0x11.
//  2. Same cycle X r3=0x11 and Y r5=0x22, then idle:
//     -> cycle+1 writes r3=0x11; cycle+2 writes r5=0x22; buffer empty after.
//  3. Y r7 buffered (X r3 busy), then X r7=0x99 with Y r7 squash:
//     -> the pop of the squashed entry gives wb_rf_writereg=0; r7 final value 0x99.
//  4. X valid every cycle with Y valid every cycle (BUF_DEPTH=4, STALL_MARGIN=2):
//     -> wb_is_stall=1 the cycle after count reaches 2; 5th Y sets wb_overflow=1.
//  5. X r0 and Y r0 -> no write issued, buffer count stays 0.
//  6. Buffer holding 3 entries, reset pulsed 1 cycle:
//     -> all outputs 0; no writes issued after reset deasserts.

Source files
------------

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Merges the X (1-cycle ALU) and Y (4-stage multiplier) result streams onto
//   the single register-file write port. X always wins a conflict. A displaced
//   Y result waits in a small in-order buffer. A younger X write squashes any
//   older buffered Y write to the same register (WAW). The issue stage is
//   back-pressured before the buffer can overflow.
//
// Optional feature: define WB_STATS_EN to add the wb_stat_* counter ports.
//
// Ports
//   clock, reset             rising-edge clock, synchronous active-high reset
//   x_wb_regdest/writereg/wbvalue   X result (regdest 0 = not valid)
//   y_wb_regdest/writereg/wbvalue   Y result (regdest 0 = not valid)
//   wb_rf_writereg/regdest/wbvalue  registered register-file write port
//   wb_is_stall              registered stall request to the issue stage
//   wb_overflow              sticky: a Y result was dropped on a full buffer
//   wb_stat_xwrites/ywrites/conflicts  (WB_STATS_EN) 32-bit event counters
module writeback_arbiter #(
  parameter int BUF_DEPTH    = 4,
  parameter int STALL_MARGIN = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  x_wb_regdest,
  input  logic        x_wb_writereg,
  input  logic [31:0] x_wb_wbvalue,
  input  logic [4:0]  y_wb_regdest,
  input  logic        y_wb_writereg,
  input  logic [31:0] y_wb_wbvalue,
  output logic        wb_rf_writereg,
  output logic [4:0]  wb_rf_regdest,
  output logic [31:0] wb_rf_wbvalue,
  output logic        wb_is_stall,
  output logic        wb_overflow
`ifdef WB_STATS_EN
  ,
  output logic [31:0] wb_stat_xwrites,
  output logic [31:0] wb_stat_ywrites,
  output logic [31:0] wb_stat_conflicts
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  logic [BUF_DEPTH-1:0]       buf_vld;
  logic [BUF_DEPTH-1:0][4:0]  buf_rd;
  logic [BUF_DEPTH-1:0][31:0] buf_val;
  logic [PW-1:0]              rd_ptr, wr_ptr;
  logic [CW-1:0]              count, next_count, free_next;

  logic        x_v, y_v, empty, full;
  logic        sel_x, sel_buf, sel_y;
  logic        pop, push_req, push;
  logic        sel_we;
  logic [4:0]  sel_rd;
  logic [31:0] sel_val;

  assign x_v   = x_wb_writereg && (x_wb_regdest != 5'd0);
  assign y_v   = y_wb_writereg && (y_wb_regdest != 5'd0);
  assign empty = (count == '0);
  assign full  = (count == CW'(BUF_DEPTH));

  assign sel_x   = x_v;
  assign sel_buf = !x_v && !empty;
  assign sel_y   = !x_v && empty && y_v;
  assign pop     = sel_buf;

  // A Y to the same register as the winning X is older-by-definition dead.
  assign push_req = (sel_x && y_v && (y_wb_regdest != x_wb_regdest)) ||
                    (sel_buf && y_v);
  // Pop only happens without X, so a full buffer can still accept in that case.
  assign push     = push_req && !(full && !pop);

  assign next_count = count + CW'(push) - CW'(pop);
  assign free_next  = CW'(BUF_DEPTH) - next_count;

  always_comb begin
    sel_we  = 1'b0;
    sel_rd  = x_wb_regdest;
    sel_val = x_wb_wbvalue;
    if (sel_x) begin
      sel_we = 1'b1;
    end else if (sel_buf) begin
      // Squashed entries still drain, just without a write.
      sel_we  = buf_vld[rd_ptr];
      sel_rd  = buf_rd[rd_ptr];
      sel_val = buf_val[rd_ptr];
    end else if (sel_y) begin
      sel_we  = 1'b1;
      sel_rd  = y_wb_regdest;
      sel_val = y_wb_wbvalue;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_vld        <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      wb_rf_writereg <= 1'b0;
      wb_rf_regdest  <= 5'd0;
      wb_rf_wbvalue  <= 32'd0;
      wb_is_stall    <= 1'b0;
      wb_overflow    <= 1'b0;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++)
        if (sel_x && buf_rd[i] == x_wb_regdest) buf_vld[i] <= 1'b0;
      if (pop) begin
        buf_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      if (push) begin
        buf_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (push_req && !push) wb_overflow <= 1'b1;
      count          <= next_count;
      wb_is_stall    <= (free_next <= CW'(STALL_MARGIN));
      wb_rf_writereg <= sel_we;
      if (sel_we) begin
        wb_rf_regdest <= sel_rd;
        wb_rf_wbvalue <= sel_val;
      end
    end
  end

  // Payload needs no reset; validity is tracked by buf_vld and count.
  always_ff @(posedge clock) begin
    if (push) begin
      buf_rd[wr_ptr]  <= y_wb_regdest;
      buf_val[wr_ptr] <= y_wb_wbvalue;
    end
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_stat_xwrites   <= 32'd0;
      wb_stat_ywrites   <= 32'd0;
      wb_stat_conflicts <= 32'd0;
    end else begin
      if (sel_x) wb_stat_xwrites <= wb_stat_xwrites + 32'd1;
      if ((sel_buf && buf_vld[rd_ptr]) || sel_y)
        wb_stat_ywrites <= wb_stat_ywrites + 32'd1;
      if (push) wb_stat_conflicts <= wb_stat_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  x_wb_regdest, y_wb_regdest;
  logic        x_wb_writereg, y_wb_writereg;
  logic [31:0] x_wb_wbvalue, y_wb_wbvalue;
  logic        wb_rf_writereg;
  logic [4:0]  wb_rf_regdest;
  logic [31:0] wb_rf_wbvalue;
  logic        wb_is_stall, wb_overflow;
`ifdef WB_STATS_EN
  logic [31:0] wb_stat_xwrites, wb_stat_ywrites, wb_stat_conflicts;
`endif

  int checks = 0;
  int errors = 0;

  writeback_arbiter #(.BUF_DEPTH(4), .STALL_MARGIN(2)) dut (
    .clock(clock), .reset(reset),
    .x_wb_regdest(x_wb_regdest), .x_wb_writereg(x_wb_writereg), .x_wb_wbvalue(x_wb_wbvalue),
    .y_wb_regdest(y_wb_regdest), .y_wb_writereg(y_wb_writereg), .y_wb_wbvalue(y_wb_wbvalue),
    .wb_rf_writereg(wb_rf_writereg), .wb_rf_regdest(wb_rf_regdest),
    .wb_rf_wbvalue(wb_rf_wbvalue), .wb_is_stall(wb_is_stall), .wb_overflow(wb_overflow)
`ifdef WB_STATS_EN
    , .wb_stat_xwrites(wb_stat_xwrites), .wb_stat_ywrites(wb_stat_ywrites),
    .wb_stat_conflicts(wb_stat_conflicts)
`endif
  );

  always #5 clock = ~clock;

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic drv(input logic xv, input logic [4:0] xr, input logic [31:0] xd,
                     input logic yv, input logic [4:0] yr, input logic [31:0] yd);
    x_wb_writereg = xv; x_wb_regdest = xr; x_wb_wbvalue = xd;
    y_wb_writereg = yv; y_wb_regdest = yr; y_wb_wbvalue = yd;
  endtask

  task automatic idle();
    drv(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; cyc(); cyc(); reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue, wb_is_stall, wb_overflow} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs got we=%0b rd=%0d val=%h stall=%0b ovf=%0b exp all 0",
               wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue, wb_is_stall, wb_overflow);
    end
  endtask

  task automatic test_x_only();
    do_reset();
    drv(1, 5'd3, 32'h11, 0, 5'd0, 32'd0); cyc(); idle();
    checks++;
    if ({wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue} !== {1'b1, 5'd3, 32'h11}) begin
      errors++;
      $display("FAIL x_only got we=%0b rd=%0d val=%h exp we=1 rd=3 val=11",
               wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue);
    end
    cyc();
    checks++;
    if ({wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue} !== {1'b0, 5'd3, 32'h11}) begin
      errors++;
      $display("FAIL x_only_hold got we=%0b rd=%0d val=%h exp we=0 rd=3 val=11",
               wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    drv(1, 5'd3, 32'h11, 1, 5'd5, 32'h22); cyc(); idle();
    checks++;
    if ({wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue} !== {1'b1, 5'd3, 32'h11}) begin
      errors++;
      $display("FAIL conflict_x got we=%0b rd=%0d val=%h exp we=1 rd=3 val=11",
               wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue);
    end
    cyc();
    checks++;
    if ({wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue} !== {1'b1, 5'd5, 32'h22}) begin
      errors++;
      $display("FAIL conflict_y got we=%0b rd=%0d val=%h exp we=1 rd=5 val=22",
               wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue);
    end
    cyc();
    checks++;
    if (wb_rf_writereg !== 1'b0) begin
      errors++;
      $display("FAIL conflict_empty got we=%0b exp 0", wb_rf_writereg);
    end
    // Empty buffer: a lone Y goes straight through.
    drv(0, 5'd0, 32'd0, 1, 5'd9, 32'h33); cyc(); idle();
    checks++;
    if ({wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue} !== {1'b1, 5'd9, 32'h33}) begin
      errors++;
      $display("FAIL y_direct got we=%0b rd=%0d val=%h exp we=1 rd=9 val=33",
               wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue);
    end
  endtask

  task automatic test_waw();
    do_reset();
    drv(1, 5'd3, 32'h11, 1, 5'd7, 32'h55); cyc();   // r7 buffered
    drv(1, 5'd7, 32'h99, 1, 5'd7, 32'h77); cyc();   // squash entry + incoming Y
    idle();
    checks++;
    if ({wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue} !== {1'b1, 5'd7, 32'h99}) begin
      errors++;
      $display("FAIL waw_x got we=%0b rd=%0d val=%h exp we=1 rd=7 val=99",
               wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue);
    end
    cyc();   // squashed head pops without a write
    checks++;
    if ({wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue} !== {1'b0, 5'd7, 32'h99}) begin
      errors++;
      $display("FAIL waw_pop got we=%0b rd=%0d val=%h exp we=0 rd=7 val=99",
               wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue);
    end
    cyc();   // discarded Y must not appear
    checks++;
    if ({wb_rf_writereg, wb_rf_wbvalue} !== {1'b0, 32'h99}) begin
      errors++;
      $display("FAIL waw_discard got we=%0b val=%h exp we=0 val=99",
               wb_rf_writereg, wb_rf_wbvalue);
    end
  endtask

  task automatic test_stall_overflow();
    logic [1:0] exp_stall [5];
    exp_stall = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};  // {ovf, stall} after each cycle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drv(1, 5'(1 + i), 32'(32'h100 + i), 1, 5'(11 + i), 32'(32'h200 + i));
      cyc();
      checks++;
      if ({wb_overflow, wb_is_stall} !== exp_stall[i]) begin
        errors++;
        $display("FAIL stall_ovf_c%0d got ovf=%0b stall=%0b exp ovf=%0b stall=%0b",
                 i, wb_overflow, wb_is_stall, exp_stall[i][1], exp_stall[i][0]);
      end
      checks++;
      if ({wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue} !== {1'b1, 5'(1 + i), 32'(32'h100 + i)}) begin
        errors++;
        $display("FAIL stall_x_c%0d got we=%0b rd=%0d val=%h exp rd=%0d", i,
                 wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue, 1 + i);
      end
    end
    idle();
    // Drain: the four accepted Y results in order; the fifth was dropped.
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (i < 4) begin
        if ({wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue} !== {1'b1, 5'(11 + i), 32'(32'h200 + i)}) begin
          errors++;
          $display("FAIL drain_%0d got we=%0b rd=%0d val=%h exp rd=%0d val=%h", i,
                   wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue, 11 + i, 32'h200 + i);
        end
      end else if ({wb_rf_writereg, wb_overflow, wb_is_stall} !== 3'b010) begin
        errors++;
        $display("FAIL drain_end got we=%0b ovf=%0b stall=%0b exp we=0 ovf=1 stall=0",
                 wb_rf_writereg, wb_overflow, wb_is_stall);
      end
    end
  endtask

  task automatic test_r0();
    do_reset();
    drv(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB); cyc(); idle();
    checks++;
    if ({wb_rf_writereg, wb_is_stall} !== 2'b00) begin
      errors++;
      $display("FAIL r0_write got we=%0b stall=%0b exp 0 0", wb_rf_writereg, wb_is_stall);
    end
    // Buffer must still be empty: a lone Y passes directly.
    drv(0, 5'd0, 32'd0, 1, 5'd9, 32'h44); cyc(); idle();
    checks++;
    if ({wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue} !== {1'b1, 5'd9, 32'h44}) begin
      errors++;
      $display("FAIL r0_empty got we=%0b rd=%0d val=%h exp we=1 rd=9 val=44",
               wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv(1, 5'(1 + i), 32'(i), 1, 5'(20 + i), 32'(32'h300 + i)); cyc();
    end
    checks++;
    if (wb_is_stall !== 1'b1) begin
      errors++;
      $display("FAIL mid_stall got %0b exp 1", wb_is_stall);
    end
    idle(); reset = 1'b1; cyc(); reset = 1'b0;
    checks++;
    if ({wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue, wb_is_stall, wb_overflow} !== 40'd0) begin
      errors++;
      $display("FAIL mid_reset got we=%0b rd=%0d val=%h stall=%0b ovf=%0b exp all 0",
               wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue, wb_is_stall, wb_overflow);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if ({wb_rf_writereg, wb_is_stall} !== 2'b00) begin
        errors++;
        $display("FAIL mid_after_%0d got we=%0b stall=%0b exp 0 0", i, wb_rf_writereg, wb_is_stall);
      end
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_x_only();
    test_conflict();
    test_waw();
    test_stall_overflow();
    test_r0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
